// File: rtl/ecu_fetch.sv
// Byte-granular instruction prefetch queue for the execution control unit.
// Fills from a req/ack memory port and presents a 4-byte window to the decoder.
module ecu_fetch #(
  parameter int AW    = 16,
  parameter int FW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req,
  output logic [AW-1:0]              mem_addr,
  input  logic                       mem_ack,
  input  logic [FW-1:0]              mem_data,
  input  logic                       redir,
  input  logic [AW-1:0]              redir_addr,
  output logic [31:0]                win,
  output logic [$clog2(DEPTH+1)-1:0] avail,
  output logic [AW-1:0]              ipc,
  input  logic                       pop,
  input  logic [1:0]                 pop_len,
  output logic                       err
);

  localparam int FB = FW / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(FB);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] ipc_q, ipc_d;
  logic          err_q, err_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [7:0]    qbuf_q [DEPTH];
  logic [7:0]    qbuf_d [DEPTH];

  logic [CW-1:0] free_cur;
  logic [CW-1:0] pop_n;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_sub;
  logic          pop_ok;
  logic          push_en;
  logic          pop_en;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ipc_d      = ipc_q;
    err_d      = 1'b0;
    skip_d     = skip_q;
    qbuf_d     = qbuf_q;

    free_cur = CW'(DEPTH) - count_q;
    pop_n    = CW'(pop_len) + CW'(1);
    pop_ok   = (pop_n <= count_q);
    push_en  = (state_q == REQ) && mem_ack && !redir;
    pop_en   = pop && pop_ok && !redir;
    push_n   = push_en ? (CW'(FB) - CW'(skip_q)) : '0;
    pop_sub  = pop_en ? pop_n : '0;

    // Bytes below skip belong to addresses before an unaligned redirect target.
    if (push_en) begin
      for (int i = 0; i < FB; i++) begin
        if (SW'(i) >= skip_q) begin
          qbuf_d[wr_ptr_q + PW'(i) - PW'(skip_q)] = mem_data[8*i +: 8];
        end
      end
      wr_ptr_d = wr_ptr_q + PW'(push_n);
      skip_d   = '0;
    end

    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PW'(pop_n);
      ipc_d    = ipc_q + AW'(pop_n);
    end
    err_d   = pop && !redir && !pop_ok;
    count_d = count_q + push_n - pop_sub;

    unique case (state_q)
      IDLE: begin
        if (free_cur >= CW'(FB)) begin
          state_d   = REQ;
          mem_req_d = 1'b1;
        end
      end
      REQ: begin
        // Address always advances on an ack so a later refill resumes in sequence.
        if (push_en) begin
          mem_addr_d = mem_addr_q + AW'(FB);
          if ((CW'(DEPTH) - count_d) < CW'(FB)) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (redir) begin
      state_d    = IDLE;
      mem_req_d  = 1'b0;
      mem_addr_d = {redir_addr[AW-1:SW], {SW{1'b0}}};
      skip_d     = redir_addr[SW-1:0];
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      ipc_d      = redir_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ipc_q      <= '0;
      err_q      <= 1'b0;
      skip_q     <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ipc_q      <= ipc_d;
      err_q      <= err_d;
      skip_q     <= skip_d;
    end
  end

  // NOTE: the byte storage is not reset; entries at or beyond count are masked
  // in the window, so stale contents are never observable.
  always_ff @(posedge clk) begin
    qbuf_q <= qbuf_d;
  end

  always_comb begin
    win = '0;
    for (int k = 0; k < 4; k++) begin
      if (CW'(k) < count_q) begin
        win[8*k +: 8] = qbuf_q[rd_ptr_q + PW'(k)];
      end
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign avail    = count_q;
  assign ipc      = ipc_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ecu_fetch.sv
// Directed scoreboard bench for ecu_fetch (AW=16, FW=32, DEPTH=8): fill, pop,
// unaligned redirect, illegal pop, push/pop overlap, address wrap and reset.
module tb_ecu_fetch;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        redir;
  logic [15:0] redir_addr;
  logic [31:0] win;
  logic [3:0]  avail;
  logic [15:0] ipc;
  logic        pop;
  logic [1:0]  pop_len;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] win;
    logic [3:0]  avail;
    logic [15:0] ipc;
  } exp_t;

  exp_t sb[$];

  ecu_fetch #(.AW(16), .FW(32), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .redir      (redir),
    .redir_addr (redir_addr),
    .win        (win),
    .avail      (avail),
    .ipc        (ipc),
    .pop        (pop),
    .pop_len    (pop_len),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the window state expected right after the next clock edge.
  task automatic expect_q(input string tag, input logic [31:0] w, input logic [3:0] a,
                          input logic [15:0] i);
    exp_t e;
    e.tag = tag; e.win = w; e.avail = a; e.ipc = i;
    sb.push_back(e);
  endtask

  // Advance one edge, sample 1ns later, and drain the scoreboard against the DUT.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".win"},   win,   e.win);
      check({e.tag, ".avail"}, {28'd0, avail}, {28'd0, e.avail});
      check({e.tag, ".ipc"},   {16'd0, ipc},   {16'd0, e.ipc});
    end
  endtask

  task automatic wait_req(input string tag, input logic [15:0] addr);
    int n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    check({tag, ".req"},  {31'd0, mem_req}, 32'd1);
    check({tag, ".addr"}, {16'd0, mem_addr}, {16'd0, addr});
  endtask

  task automatic ack(input logic [31:0] data);
    mem_ack  = 1'b1;
    mem_data = data;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_data = '0; redir = 1'b0; redir_addr = '0;
    pop = 1'b0; pop_len = '0;

    // Reset state
    expect_q("rst", 32'h0, 4'd0, 16'h0);
    step();
    step();
    check("rst.req",  {31'd0, mem_req}, 32'd0);
    check("rst.addr", {16'd0, mem_addr}, 32'd0);
    check("rst.err",  {31'd0, err}, 32'd0);

    // 1: first request one edge after reset release, fill the queue
    rst = 1'b0;
    step();
    check("t1.req",  {31'd0, mem_req}, 32'd1);
    check("t1.addr", {16'd0, mem_addr}, 32'h0);
    ack(32'h44332211);
    expect_q("t1.ack0", 32'h44332211, 4'd4, 16'h0);
    step();
    check("t1.addr4", {16'd0, mem_addr}, 32'h4);
    check("t1.req4",  {31'd0, mem_req}, 32'd1);
    ack(32'h88776655);
    expect_q("t1.ack1", 32'h44332211, 4'd8, 16'h0);
    step();
    mem_ack = 1'b0;
    check("t1.full_req", {31'd0, mem_req}, 32'd0);

    // 2: two 2-byte pops, then refill request resumes at 8
    pop = 1'b1; pop_len = 2'd1;
    expect_q("t2.pop0", 32'h66554433, 4'd6, 16'h2);
    step();
    expect_q("t2.pop1", 32'h88776655, 4'd4, 16'h4);
    step();
    pop = 1'b0;
    check("t2.req_low", {31'd0, mem_req}, 32'd0);
    step();
    check("t2.req",  {31'd0, mem_req}, 32'd1);
    check("t2.addr", {16'd0, mem_addr}, 32'h8);

    // 3: unaligned redirect to 0x13
    redir = 1'b1; redir_addr = 16'h0013;
    expect_q("t3.redir", 32'h0, 4'd0, 16'h0013);
    step();
    redir = 1'b0;
    check("t3.req0", {31'd0, mem_req}, 32'd0);
    wait_req("t3.fetch", 16'h0010);
    ack(32'hDDCCBBAA);
    expect_q("t3.ack", 32'h000000DD, 4'd1, 16'h0013);
    step();
    mem_ack = 1'b0;
    check("t3.next", {16'd0, mem_addr}, 32'h0014);

    // 4: illegal pop leaves queue intact and pulses err once
    pop = 1'b1; pop_len = 2'd2;
    expect_q("t4.bad", 32'h000000DD, 4'd1, 16'h0013);
    step();
    check("t4.err1", {31'd0, err}, 32'd1);
    pop = 1'b0;
    step();
    check("t4.err0", {31'd0, err}, 32'd0);
    pop = 1'b1; pop_len = 2'd0;
    expect_q("t4.pop1", 32'h0, 4'd0, 16'h0014);
    step();
    pop = 1'b0;
    check("t4.err_ok", {31'd0, err}, 32'd0);

    // 5: push and pop in the same cycle, then redirect drops a coincident ack
    ack(32'h04030201);
    expect_q("t5.fill", 32'h04030201, 4'd4, 16'h0014);
    step();
    check("t5.addr18", {16'd0, mem_addr}, 32'h0018);
    ack(32'h08070605);
    pop = 1'b1; pop_len = 2'd3;
    expect_q("t5.both", 32'h08070605, 4'd4, 16'h0018);
    step();
    check("t5.addr1c", {16'd0, mem_addr}, 32'h001C);
    pop_len = 2'd0;
    ack(32'hCAFEF00D);
    redir = 1'b1; redir_addr = 16'h0040;
    expect_q("t5.drop", 32'h0, 4'd0, 16'h0040);
    step();
    mem_ack = 1'b0; pop = 1'b0; redir = 1'b0;
    check("t5.req",  {31'd0, mem_req}, 32'd0);
    check("t5.addr", {16'd0, mem_addr}, 32'h0040);
    check("t5.err",  {31'd0, err}, 32'd0);

    // 6: redirect near the top of the address space, wrap, then reset mid-request
    redir = 1'b1; redir_addr = 16'hFFFE;
    expect_q("t6.redir", 32'h0, 4'd0, 16'hFFFE);
    step();
    redir = 1'b0;
    wait_req("t6.fetch", 16'hFFFC);
    ack(32'h2211BBAA);
    expect_q("t6.ack", 32'h00002211, 4'd2, 16'hFFFE);
    step();
    mem_ack = 1'b0;
    check("t6.wrap_addr", {16'd0, mem_addr}, 32'h0000);
    check("t6.wrap_req",  {31'd0, mem_req}, 32'd1);
    pop = 1'b1; pop_len = 2'd1;
    expect_q("t6.pop", 32'h0, 4'd0, 16'h0000);
    step();
    pop = 1'b0;
    check("t6.req_pre", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    expect_q("t6.rst", 32'h0, 4'd0, 16'h0);
    step();
    check("t6.rst_req",  {31'd0, mem_req}, 32'd0);
    check("t6.rst_addr", {16'd0, mem_addr}, 32'd0);
    check("t6.rst_err",  {31'd0, err}, 32'd0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
